// File: rtl/booth_multiplier.sv
// Purpose: signed two's-complement multiplier using fully unrolled radix-2 Booth recoding.
// Latency: 1 cycle; the product of a/b sampled at a rising edge appears on out after that edge.
// Backpressure: none; a new operand pair is accepted every cycle and out is always valid.
//
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset; clears out immediately
//   a    - WIDTH-bit signed multiplicand
//   b    - WIDTH-bit signed multiplier (Booth-recoded)
//   out  - 2*WIDTH-bit signed product, registered
module booth_multiplier #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic [2*WIDTH-1:0]   out
);

  // Booth pair encodings, named by {b[i], b[i-1]}.
  localparam logic [1:0] PAIR_ADD = 2'b01;
  localparam logic [1:0] PAIR_SUB = 2'b10;

  logic [2*WIDTH-1:0] out_d;
  logic [2*WIDTH-1:0] out_q;

  // One complete Booth multiply. The accumulator is {hi, lo, q_m1}:
  //   hi   - upper part, WIDTH+1 bits so that subtracting the most negative
  //          multiplicand (which negates to +2^(WIDTH-1)) cannot overflow
  //   lo   - starts as the multiplier; product bits shift into it from hi
  //   q_m1 - the bit shifted out of lo, i.e. b[i-1] for the next step
  // After WIDTH steps the product is the low 2*WIDTH bits of {hi, lo}.
  function automatic logic [2*WIDTH-1:0] booth_product(
    input logic [WIDTH-1:0] mcand,
    input logic [WIDTH-1:0] mplier
  );
    logic [WIDTH:0]   hi;
    logic [WIDTH:0]   mcand_ext;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] lo;
    logic             q_m1;

    hi        = '0;
    lo        = mplier;
    q_m1      = 1'b0;
    mcand_ext = {mcand[WIDTH-1], mcand};

    for (int i = 0; i < WIDTH; i++) begin
      // lo[0] is b[i] at step i because lo shifts right once per step.
      case ({lo[0], q_m1})
        PAIR_ADD: sum = hi + mcand_ext;
        PAIR_SUB: sum = hi - mcand_ext;
        default:  sum = hi;
      endcase
      // Arithmetic right shift of the whole {hi, lo, q_m1} accumulator.
      q_m1 = lo[0];
      lo   = {sum[0], lo[WIDTH-1:1]};
      hi   = {sum[WIDTH], sum[WIDTH:1]};
    end

    return {hi[WIDTH-1:0], lo};
  endfunction

  always_comb begin
    out_d = booth_product(a, b);
  end

  // Reset discards any product not yet registered and holds out at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q <= '0;
    end else begin
      out_q <= out_d;
    end
  end

  assign out = out_q;

endmodule

// File: tb/tb_booth_multiplier.sv
module tb_booth_multiplier;

  localparam int WIDTH = 16;

  logic               clk;
  logic               rst;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic [2*WIDTH-1:0] out;

  int tests_run;
  int tests_failed;

  booth_multiplier #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .a   (a),
    .b   (b),
    .out (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive a pair away from the edge, then sample 1ns after the capturing edge.
  task automatic apply(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb);
    @(negedge clk);
    a = ta;
    b = tb;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    a   = 16'h1234;
    b   = 16'h0042;
    #2;
    tests_run++;
    if (out !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_async: out=%h required=%h", out, 32'h0);
    end
    @(posedge clk);
    #1;
    tests_run++;
    if (out !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_held_edge: out=%h required=%h", out, 32'h0);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    tests_run++;
    if (out !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_release_hold: out=%h required=%h", out, 32'h0);
    end
  endtask

  task automatic test_basic;
    logic [WIDTH-1:0]   va [3];
    logic [WIDTH-1:0]   vb [3];
    logic [2*WIDTH-1:0] ve [3];
    va = '{16'd4, 16'd3, 16'd5};
    vb = '{16'd3, 16'd2, 16'd5};
    ve = '{32'h0000000C, 32'h00000006, 32'h00000019};
    for (int i = 0; i < 3; i++) begin
      apply(va[i], vb[i]);
      tests_run++;
      if (out !== ve[i]) begin
        tests_failed++;
        $display("FAIL basic[%0d]: a=%h b=%h out=%h required=%h", i, va[i], vb[i], out, ve[i]);
      end
    end
  endtask

  task automatic test_signs;
    logic [WIDTH-1:0]   va [3];
    logic [WIDTH-1:0]   vb [3];
    logic [2*WIDTH-1:0] ve [3];
    va = '{16'hFFF6, 16'h000D, 16'hFFF6};   // -10, 13, -10
    vb = '{16'h000D, 16'hFFF6, 16'hFFF3};   //  13, -10, -13
    ve = '{32'hFFFFFF7E, 32'hFFFFFF7E, 32'h00000082};
    for (int i = 0; i < 3; i++) begin
      apply(va[i], vb[i]);
      tests_run++;
      if (out !== ve[i]) begin
        tests_failed++;
        $display("FAIL signs[%0d]: a=%h b=%h out=%h required=%h", i, va[i], vb[i], out, ve[i]);
      end
    end
  endtask

  task automatic test_corners;
    logic [WIDTH-1:0]   va [8];
    logic [WIDTH-1:0]   vb [8];
    logic [2*WIDTH-1:0] ve [8];
    va = '{16'h8000, 16'h8000, 16'h7FFF, 16'h0000, 16'hFFFF, 16'h0001, 16'h0003, 16'h1234};
    vb = '{16'h8000, 16'h7FFF, 16'h7FFF, 16'hFFFF, 16'hFFFF, 16'h8000, 16'h5555, 16'h0000};
    ve = '{32'h40000000, 32'hC0008000, 32'h3FFF0001, 32'h00000000,
           32'h00000001, 32'hFFFF8000, 32'h0000FFFF, 32'h00000000};
    for (int i = 0; i < 8; i++) begin
      apply(va[i], vb[i]);
      tests_run++;
      if (out !== ve[i]) begin
        tests_failed++;
        $display("FAIL corner[%0d]: a=%h b=%h out=%h required=%h", i, va[i], vb[i], out, ve[i]);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [WIDTH-1:0]          ra;
    logic [WIDTH-1:0]          rb;
    logic signed [2*WIDTH-1:0] expv;
    int                        errs;
    errs = 0;
    for (int i = 0; i < 1000; i++) begin
      ra = WIDTH'($urandom);
      rb = WIDTH'($urandom);
      expv = $signed(ra) * $signed(rb);
      apply(ra, rb);
      tests_run++;
      if (out !== expv) begin
        tests_failed++;
        errs++;
        if (errs <= 10)
          $display("FAIL back_to_back[%0d]: a=%h b=%h out=%h required=%h", i, ra, rb, out, expv);
      end
    end
  endtask

  task automatic test_mid_reset;
    apply(16'h0011, 16'h0013);   // 17*19 = 323
    tests_run++;
    if (out !== 32'h00000143) begin
      tests_failed++;
      $display("FAIL mid_reset_pre: out=%h required=%h", out, 32'h00000143);
    end
    @(negedge clk);
    a   = 16'd7;
    b   = 16'd6;
    rst = 1'b1;
    #1;
    tests_run++;
    if (out !== 32'h0) begin
      tests_failed++;
      $display("FAIL mid_reset_async: out=%h required=%h", out, 32'h0);
    end
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if (out !== 32'h0) begin
      tests_failed++;
      $display("FAIL mid_reset_hold: out=%h required=%h", out, 32'h0);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    tests_run++;
    if (out !== 32'h0) begin
      tests_failed++;
      $display("FAIL mid_reset_release: out=%h required=%h", out, 32'h0);
    end
    @(posedge clk);
    #1;
    tests_run++;
    if (out !== 32'h0000002A) begin
      tests_failed++;
      $display("FAIL mid_reset_first_edge: out=%h required=%h", out, 32'h0000002A);
    end
    // Output must not follow inputs between edges.
    @(negedge clk);
    a = 16'd100;
    b = 16'd100;
    #2;
    tests_run++;
    if (out !== 32'h0000002A) begin
      tests_failed++;
      $display("FAIL stable_between_edges: out=%h required=%h", out, 32'h0000002A);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst = 1'b1;
    a   = '0;
    b   = '0;
    test_reset();
    test_basic();
    test_signs();
    test_corners();
    test_back_to_back();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
